// File: rtl/weight_bank_loader.sv
// Loads NUM_WEIGHTS bytes from a valid/ready stream into the weight bank, one setup/strobe/hold write per byte.
// Latency: 2 cycles from handshake to write strobe, at least 4 cycles per weight. Backpressure: in_ready only in ACCEPT.
module weight_bank_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_WEIGHTS = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_address;
    logic                  r_write;
    logic                  r_busy;
    logic                  r_done;

    logic w_accept;
    assign w_accept = in_valid & r_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_data     <= '0;
            r_address  <= '0;
            r_write    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACCEPT;
                        r_address  <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (w_accept) begin
                        r_data     <= in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_write <= 1'b1;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    r_write <= 1'b0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    // Terminal check precedes the increment, so the address never wraps mid-load.
                    if (r_address == LAST_ADDR) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_address  <= r_address + 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ACCEPT;
                    end
                end
                S_DONE: begin
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_address <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign dataOut  = r_data;
    assign address  = r_address;
    assign write    = r_write;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Bench for weight_bank_loader: a reacting byte source plus a per-cycle waveform model built from the timing rules.
module tb_weight_bank_loader;

    typedef logic [7:0] wv_t [4];
    typedef int st_t [4];

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dataOut;
    logic [1:0] address;
    logic       write;
    logic       busy;
    logic       done;

    weight_bank_loader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dataOut (dataOut),
        .address (address),
        .write   (write),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc;
    bit hs_now;
    logic [7:0] last_byte;

    // Observed sample per cycle: {busy, done, write, in_ready, address[1:0], dataOut[7:0]}
    logic [13:0] obs [256];
    bit          e_busy [256];
    bit          e_done [256];
    bit          e_wr   [256];
    bit          e_rdy  [256];
    logic [1:0]  e_addr [256];
    logic [7:0]  e_dout [256];

    task automatic mark();
        cyc    = 0;
        hs_now = 1'b0;
        obs[0] = {busy, done, write, in_ready, address, dataOut};
    endtask

    task automatic step();
        bit v;
        bit r;
        v = in_valid;
        r = in_ready;
        @(posedge clk);
        #1;
        cyc++;
        hs_now = v && r;
        if (cyc < 256) obs[cyc] = {busy, done, write, in_ready, address, dataOut};
    endtask

    // Expected waveform from the load rules: ready until handshake, strobe one cycle after
    // the handshake edge's successor, hold, then next ready; done one cycle after last hold.
    task automatic model_load(input int from, input int n, input wv_t b, input st_t st,
                              input logic [7:0] prev, output int L, output int hs [4]);
        int ref_c;
        int e;
        int acc;
        ref_c = n;
        for (int k = 0; k < 4; k++) begin
            e     = (k == 0) ? n + 1 : ref_c + 4;
            hs[k] = (e > ref_c + st[k] + 1) ? e : ref_c + st[k] + 1;
            ref_c = hs[k];
        end
        L = hs[3];
        for (int s = from; s <= L + 4 && s < 256; s++) begin
            e_busy[s] = (s >= n && s <= L + 3);
            e_done[s] = (s == L + 3);
            e_wr[s]   = 1'b0;
            e_rdy[s]  = 1'b0;
            e_addr[s] = (s == L + 3) ? 2'd3 : 2'd0;
            e_dout[s] = prev;
            for (int k = 0; k < 4; k++) begin
                acc = (k == 0) ? n : hs[k-1] + 3;
                if (s >= acc && s <= hs[k] + 2) e_addr[s] = 2'(k);
                if (s >= acc && s < hs[k]) e_rdy[s] = 1'b1;
                if (s == hs[k] + 1) e_wr[s] = 1'b1;
                if (s >= hs[k]) e_dout[s] = b[k];
            end
        end
    endtask

    // Source: waits st[k] cycles after the previous handshake, then offers b[k] until taken.
    task automatic drive_load(input wv_t b, input st_t st, input int poke_k,
                              output int n, output int hs_o [4]);
        int ref_c;
        int guard;
        for (int k = 0; k < 4; k++) hs_o[k] = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        n     = cyc;
        ref_c = n;
        for (int k = 0; k < 4; k++) begin
            while (cyc < ref_c + st[k]) step();
            in_valid = 1'b1;
            in_data  = b[k];
            guard    = 0;
            do begin
                step();
                guard++;
            end while (!hs_now && guard < 60);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (!hs_now) begin
                n_cmp++;
                n_fail++;
                $display("FAIL handshake_timeout k=%0d: no handshake after %0d cycles, required one", k, guard);
                return;
            end
            hs_o[k] = cyc;
            ref_c   = cyc;
            if (k == poke_k) begin
                step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got %b required 1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, write, in_ready, address, dataOut} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required 0", {busy, done, write, in_ready, address, dataOut});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        mark();
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (obs[cyc] !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h required 0", i, obs[cyc]);
            end
        end
        last_byte = 8'h00;
    endtask

    task automatic test_back_to_back();
        wv_t b;
        st_t st;
        int n, Lm, w, d;
        int hs_o [4];
        int hs_m [4];
        b  = '{8'h11, 8'h22, 8'h33, 8'h44};
        st = '{0, 0, 0, 0};
        mark();
        model_load(0, 1, b, st, last_byte, Lm, hs_m);
        drive_load(b, st, -1, n, hs_o);
        while (cyc < Lm + 4) step();
        for (int s = 0; s <= Lm + 4; s++) begin
            n_cmp++;
            if (obs[s] !== {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]}) begin
                n_fail++;
                $display("FAIL b2b_wave cycle %0d: got %b required %b", s, obs[s],
                         {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]});
            end
        end
        w = 0;
        d = -100;
        for (int s = 0; s <= Lm + 4; s++) begin
            w += int'(obs[s][11]);
            if (obs[s][12]) d = s;
        end
        n_cmp++;
        if (w !== 4) begin
            n_fail++;
            $display("FAIL b2b_write_count: got %0d required 4", w);
        end
        n_cmp++;
        if ((d + 1) - (n - 1) !== 18) begin
            n_fail++;
            $display("FAIL b2b_load_cycles: got %0d required 18", (d + 1) - (n - 1));
        end
        last_byte = b[3];
    endtask

    task automatic test_stall();
        wv_t b;
        st_t st;
        int n, Lm;
        int hs_o [4];
        int hs_m [4];
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        b[2] = 8'hA5;
        st   = '{0, 0, 8, 0};
        mark();
        model_load(0, 1, b, st, last_byte, Lm, hs_m);
        drive_load(b, st, -1, n, hs_o);
        while (cyc < Lm + 4) step();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (hs_o[k] !== hs_m[k]) begin
                n_fail++;
                $display("FAIL stall_hs_cycle k=%0d: got %0d required %0d", k, hs_o[k], hs_m[k]);
            end
        end
        for (int s = 0; s <= Lm + 4; s++) begin
            n_cmp++;
            if (obs[s] !== {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]}) begin
                n_fail++;
                $display("FAIL stall_wave cycle %0d: got %b required %b", s, obs[s],
                         {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]});
            end
        end
        n_cmp++;
        if (hs_o[2] < 0 || obs[hs_o[2] + 1][11:0] !== {1'b1, 1'b0, 2'd2, 8'hA5}) begin
            n_fail++;
            $display("FAIL stall_a5_write: got %b required 1_0_10_10100101",
                     (hs_o[2] < 0) ? 12'd0 : obs[hs_o[2] + 1][11:0]);
        end
        last_byte = b[3];
    endtask

    task automatic test_random_load(input int max_stall, input int poke_k, input int tag);
        wv_t b;
        st_t st;
        int n, Lm, w;
        int hs_o [4];
        int hs_m [4];
        for (int i = 0; i < 4; i++) begin
            b[i]  = 8'($urandom);
            st[i] = int'($urandom_range(0, max_stall));
        end
        mark();
        model_load(0, 1, b, st, last_byte, Lm, hs_m);
        drive_load(b, st, poke_k, n, hs_o);
        while (cyc < Lm + 4) step();
        w = 0;
        for (int s = 0; s <= Lm + 4; s++) begin
            w += int'(obs[s][11]);
            n_cmp++;
            if (obs[s] !== {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]}) begin
                n_fail++;
                $display("FAIL rand%0d_wave cycle %0d: got %b required %b", tag, s, obs[s],
                         {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]});
            end
        end
        n_cmp++;
        if (w !== 4) begin
            n_fail++;
            $display("FAIL rand%0d_write_count: got %0d required 4", tag, w);
        end
        last_byte = b[3];
    endtask

    task automatic test_ignored();
        // Valid offered during SETUP/STROBE/HOLD, start pulsed in the address-1 strobe.
        test_random_load(2, 1, 100);
    endtask

    task automatic test_reset_mid();
        int hs_cnt;
        int guard;
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        hs_cnt   = 0;
        guard    = 0;
        while (hs_cnt < 2 && guard < 40) begin
            step();
            guard++;
            if (hs_now) begin
                hs_cnt++;
                in_data = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if ({write, address} !== 3'b101) begin
            n_fail++;
            $display("FAIL rstmid_pre_strobe: got write/addr %b required 101", {write, address});
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, write, in_ready, address} !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy/wr/rdy/addr %b required 00000", {busy, write, in_ready, address});
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        last_byte = 8'h00;
        test_random_load(3, -1, 200);
    endtask

    task automatic test_consecutive();
        wv_t b1, b2;
        st_t st1, st2;
        int n1, n2, Lm1, Lm2;
        int hs_o [4];
        int hs_m [4];
        for (int i = 0; i < 4; i++) begin
            b1[i]  = 8'($urandom);
            b2[i]  = 8'($urandom);
            st1[i] = int'($urandom_range(0, 3));
            st2[i] = int'($urandom_range(0, 3));
        end
        mark();
        model_load(0, 1, b1, st1, last_byte, Lm1, hs_m);
        model_load(Lm1 + 4, Lm1 + 5, b2, st2, b1[3], Lm2, hs_m);
        drive_load(b1, st1, -1, n1, hs_o);
        while (cyc < Lm1 + 3) step();
        start = 1'b1;
        step();
        drive_load(b2, st2, -1, n2, hs_o);
        while (cyc < Lm2 + 4) step();
        for (int s = 0; s <= Lm2 + 4; s++) begin
            n_cmp++;
            if (obs[s] !== {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]}) begin
                n_fail++;
                $display("FAIL consec_wave cycle %0d: got %b required %b", s, obs[s],
                         {e_busy[s], e_done[s], e_wr[s], e_rdy[s], e_addr[s], e_dout[s]});
            end
        end
        n_cmp++;
        if (n2 !== Lm1 + 5) begin
            n_fail++;
            $display("FAIL consec_second_start: got cycle %0d required %0d", n2, Lm1 + 5);
        end
        last_byte = b2[3];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        last_byte = 8'h00;
        test_reset();
        test_back_to_back();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_consecutive();
        for (int i = 0; i < 4; i++) begin
            test_random_load(5, int'($urandom_range(0, 4)) - 1, i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
